// File: rtl/s_burst_ctrl_pkg.sv
// s_burst_ctrl_pkg: shared state encoding and default width for the stream burst controller
package s_burst_ctrl_pkg;
    localparam int SIZECOUNT_DEF = 12;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/s_burst_ctrl.sv
// s_burst_ctrl: stream burst framing with token index/size for an external count==size comparator
module s_burst_ctrl
    import s_burst_ctrl_pkg::*;
#(
    parameter int SIZECOUNT = SIZECOUNT_DEF
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SIZECOUNT-1:0] size_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [SIZECOUNT-1:0] count,
    output logic [SIZECOUNT-1:0] size,
    input  logic                 endcount,
    output logic                 busy,
    output logic                 done
);
    state_t state, state_n;
    logic   run, xfer, nonempty;
    assign nonempty = size_in != '0;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end
    always_comb begin
        state_n = abort               ? S_IDLE :
                  (state == S_IDLE)   ? (start ? (nonempty ? S_RUN : S_DONE) : S_IDLE) :
                  (state == S_RUN)    ? ((xfer && endcount) ? S_DONE : S_RUN) :
                                        S_IDLE;
    end
    always_comb begin
        run       = state == S_RUN;
        xfer      = run & in_valid & out_ready;
        in_ready  = run & out_ready;
        out_valid = run & in_valid;
        out_last  = run & in_valid & endcount;
        busy      = run;
        done      = state == S_DONE;
    end
    // size stays frozen outside IDLE so the comparator sees a stable target all burst
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
            size  <= '0;
        end else if (abort) begin
            count <= '0;
        end else if (state == S_IDLE) begin
            count <= '0;
            if (start && nonempty) size <= size_in - 1'b1;
        end else if (xfer) begin
            count <= endcount ? '0 : count + 1'b1;
        end
    end
endmodule

// File: tb/tb_s_burst_ctrl.sv
// tb_s_burst_ctrl: directed checks of s_burst_ctrl beside a count==size comparator
module tb_s_burst_ctrl;
    localparam int SC = 12;
    logic          aclk, aresetn, start, abort, in_valid, out_ready, endcount;
    logic          in_ready, out_valid, out_last, busy, done;
    logic [SC-1:0] size_in, count, size;
    logic [SC+4:0] obs;
    int            checks = 0;
    int            fails  = 0;
    s_burst_ctrl #(.SIZECOUNT(SC)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort), .size_in(size_in),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .count(count), .size(size), .endcount(endcount),
        .busy(busy), .done(done)
    );
    assign endcount = count == size;
    assign obs = {count, out_last, out_valid, in_ready, busy, done};
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    task automatic step;
        @(posedge aclk);
        #1;
    endtask
    task automatic test_reset;
        aresetn = 1'b0; start = 1'b0; abort = 1'b0; size_in = '0; in_valid = 1'b0; out_ready = 1'b0;
        #3;
        checks++; if (obs !== '0) begin fails++; $display("FAIL reset_outputs got %h exp %h", obs, 17'h0); end
        checks++; if (size !== '0) begin fails++; $display("FAIL reset_size got %0d exp 0", size); end
        step; step;
        aresetn = 1'b1;
    endtask
    task automatic test_basic;
        logic [SC+4:0] e;
        size_in = 12'd4; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #2;
        checks++; if (obs !== '0) begin fails++; $display("FAIL basic_idle got %h exp %h", obs, 17'h0); end
        step; start = 1'b0;
        #2;
        checks++; if (size !== 12'd3) begin fails++; $display("FAIL basic_size got %0d exp 3", size); end
        for (int i = 0; i < 4; i++) begin
            e = {SC'(i), i == 3, 4'b1110};
            checks++; if (obs !== e) begin fails++; $display("FAIL basic_tok%0d got %h exp %h", i, obs, e); end
            step; #2;
        end
        checks++; if (obs !== {12'd0, 5'b00001}) begin fails++; $display("FAIL basic_done got %h exp %h", obs, {12'd0, 5'b00001}); end
        step; #2;
        checks++; if (obs !== '0) begin fails++; $display("FAIL basic_back_idle got %h exp %h", obs, 17'h0); end
        step;
    endtask
    task automatic test_stall;
        logic          or_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int            cnt_exp[7] = '{0, 1, 1, 1, 1, 2, 3};
        int            nx = 0;
        int            dn = 0;
        logic [SC+4:0] e;
        size_in = 12'd4; start = 1'b1; in_valid = 1'b1;
        step; start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            out_ready = or_pat[c];
            #2;
            e = {SC'(cnt_exp[c]), c == 6, 1'b1, or_pat[c], 2'b10};
            checks++; if (obs !== e) begin fails++; $display("FAIL stall_cyc%0d got %h exp %h", c, obs, e); end
            if (in_ready && in_valid) nx++;
            step;
        end
        checks++; if (nx !== 4) begin fails++; $display("FAIL stall_xfers got %0d exp 4", nx); end
        for (int c = 0; c < 3; c++) begin
            #2; dn += int'(done); step;
        end
        checks++; if (dn !== 1) begin fails++; $display("FAIL stall_done_count got %0d exp 1", dn); end
    endtask
    task automatic test_empty;
        size_in = 12'd0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step; start = 1'b0;
        #2;
        checks++; if (obs !== {12'd0, 5'b00001}) begin fails++; $display("FAIL empty_done got %h exp %h", obs, {12'd0, 5'b00001}); end
        checks++; if (size !== 12'd3) begin fails++; $display("FAIL empty_size_kept got %0d exp 3", size); end
        step; #2;
        checks++; if (obs !== '0) begin fails++; $display("FAIL empty_idle got %h exp %h", obs, 17'h0); end
        step;
    endtask
    task automatic test_single;
        size_in = 12'd1; start = 1'b1;
        step; start = 1'b0;
        #2;
        checks++; if (size !== 12'd0) begin fails++; $display("FAIL single_size got %0d exp 0", size); end
        checks++; if (obs !== {12'd0, 5'b11110}) begin fails++; $display("FAIL single_last got %h exp %h", obs, {12'd0, 5'b11110}); end
        step; #2;
        checks++; if (obs !== {12'd0, 5'b00001}) begin fails++; $display("FAIL single_done got %h exp %h", obs, {12'd0, 5'b00001}); end
        step;
    endtask
    task automatic test_max;
        size_in = 12'hFFF; start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        step; start = 1'b0;
        #2;
        checks++; if (size !== 12'hFFE) begin fails++; $display("FAIL max_size got %h exp ffe", size); end
        checks++; if (obs !== {12'd0, 5'b00110}) begin fails++; $display("FAIL max_run_idle_in got %h exp %h", obs, {12'd0, 5'b00110}); end
        abort = 1'b1;
        step; abort = 1'b0;
        #2;
        checks++; if (obs !== '0) begin fails++; $display("FAIL max_abort got %h exp %h", obs, 17'h0); end
        step;
    endtask
    task automatic test_abort;
        int dn = 0;
        size_in = 12'd6; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step; start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (count !== SC'(c)) begin fails++; $display("FAIL abort_cnt%0d got %0d exp %0d", c, count, c); end
            if (c == 2) abort = 1'b1;
            step;
        end
        abort = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #2; dn += int'(done);
            checks++; if (obs !== '0) begin fails++; $display("FAIL abort_idle%0d got %h exp %h", c, obs, 17'h0); end
            step;
        end
        checks++; if (dn !== 0) begin fails++; $display("FAIL abort_no_done got %0d exp 0", dn); end
        size_in = 12'd2; start = 1'b1;
        step; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++; if (obs !== {SC'(i), i == 1, 4'b1110}) begin fails++; $display("FAIL after_abort_tok%0d got %h exp %h", i, obs, {SC'(i), i == 1, 4'b1110}); end
            step;
        end
        #2;
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL after_abort_done got %b exp 1", done); end
        step;
        start = 1'b1;
        step; start = 1'b0;
        step;
        abort = 1'b1;
        #2;
        checks++; if (obs !== {12'd1, 5'b11110}) begin fails++; $display("FAIL abort_final_xfer got %h exp %h", obs, {12'd1, 5'b11110}); end
        step; abort = 1'b0;
        #2;
        checks++; if (obs !== '0) begin fails++; $display("FAIL abort_final_no_done got %h exp %h", obs, 17'h0); end
        step;
    endtask
    task automatic test_reset_mid;
        size_in = 12'd8; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step; start = 1'b0;
        repeat (5) step;
        #2;
        checks++; if (count !== 12'd5) begin fails++; $display("FAIL mid_cnt got %0d exp 5", count); end
        aresetn = 1'b0;
        #1;
        checks++; if (obs !== '0) begin fails++; $display("FAIL mid_async_outputs got %h exp %h", obs, 17'h0); end
        checks++; if (size !== '0) begin fails++; $display("FAIL mid_async_size got %0d exp 0", size); end
        step;
        aresetn = 1'b1; size_in = 12'd2; start = 1'b1;
        step; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++; if (obs !== {SC'(i), i == 1, 4'b1110}) begin fails++; $display("FAIL post_reset_tok%0d got %h exp %h", i, obs, {SC'(i), i == 1, 4'b1110}); end
            step;
        end
        #2;
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL post_reset_done got %b exp 1", done); end
        step;
    endtask
    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_empty;
        test_single;
        test_max;
        test_abort;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/s_burst_ctrl.md
Name: s_burst_ctrl

Overview:
- Stream burst controller that generates the running token index `count` and the latched last-index `size` for the downstream size comparator.
- The comparator returns `endcount`, high when `count == size`. This block uses it to mark the final token of a burst and to terminate the burst.
- Sits in the coprocessor stream path between the input FIFO/actor port and the output port.
- Passes data handshakes through unchanged and adds last/done framing.

Parameters:
- SIZECOUNT, 12, width of the burst-length input and of `count`/`size`; maximum burst is 2^SIZECOUNT-1 tokens.

Ports:
- aclk  input  1  system clock, rising edge.
- aresetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE without `done`.
- size_in  input  SIZECOUNT  burst length in tokens, sampled with `start`.
- in_valid  input  1  upstream token valid.
- in_ready  output  1  upstream ready.
- out_valid  output  1  downstream token valid.
- out_ready  input  1  downstream ready.
- out_last  output  1  current output token is the last of the burst.
- count  output  SIZECOUNT  index of the current token (0-based), to the comparator.
- size  output  SIZECOUNT  latched last index (size_in-1), to the comparator.
- endcount  input  1  comparator result: count==size.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the last token transfers.

Behaviour:
- Reset (aresetn low, asynchronous): state=IDLE, count=0, size=0, done=0. Combinational outputs follow IDLE values: in_ready=0, out_valid=0, out_last=0, busy=0.
- States: IDLE, RUN, DONE; encoding is binary.
- IDLE:
  - in_ready=0, out_valid=0, count held at 0.
  - start=1 and size_in!=0: size<=size_in-1, count<=0, go to RUN next cycle.
  - start=1 and size_in==0: size unchanged, go to DONE (empty burst, done pulse still produced).
  - start=0: stay in IDLE.
- RUN:
  - Combinational pass-through: out_valid=in_valid, in_ready=out_ready, out_last=endcount&in_valid, busy=1.
  - Transfer xfer = in_valid & out_ready.
  - xfer & !endcount: count<=count+1.
  - xfer & endcount: count<=0, go to DONE.
  - No xfer: count holds; stalls of any length are allowed.
  - start is ignored in RUN; size is held constant for the whole burst.
- DONE:
  - done=1 for exactly one cycle; in_ready=0, out_valid=0, busy=0.
  - Next cycle: IDLE.
  - start in DONE is ignored.
- abort:
  - Highest priority after reset; in any state, next cycle is IDLE with count=0 and no done pulse.
  - abort coincident with a final xfer: the token transfers (the handshake is combinational) but done is suppressed.
- Latency:
  - Zero-cycle data path; `count`/`size` are registered.
  - `endcount` is expected combinational from count/size, so it is valid in the same cycle.
- Width/wrap rules:
  - count is SIZECOUNT wide.
  - If endcount never asserts (misconnection), count wraps 2^SIZECOUNT-1 -> 0 and the burst continues. No error flag.
  - size_in = 2^SIZECOUNT-1 gives size = 2^SIZECOUNT-2 with no overflow.
- Reset mid-burst: immediate return to IDLE values. Tokens in flight are the upstream/downstream owners' concern.

Decomposition:
- Shared package/header: state encodings (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2) and the default SIZECOUNT.
- No internal sub-module. The comparator is instantiated beside this block in the parent, wiring count/size out and endcount back in.
- The bench instantiates both blocks.

Test Plan:
- Reset, then start with size_in=4, in_valid=1 and out_ready=1 continuously -> size=3; count 0,1,2,3 on four consecutive cycles; out_last high only at count=3; done pulse one cycle after; back to IDLE.
- Same burst with out_ready low for 3 cycles at count=1 -> count holds at 1 during the stall; in_ready mirrors out_ready; exactly 4 transfers; done once.
- start with size_in=0 -> no transfers, in_ready stays 0, done pulses on the cycle after entering DONE.
- size_in=1 -> first token has out_last=1; count stays 0; done next cycle.
- abort at count=2 of a size_in=6 burst -> IDLE next cycle, count=0, no done; a subsequent start of size_in=2 completes normally.
- aresetn asserted mid-burst at count=5 -> outputs return to reset values asynchronously; start is accepted after release.
